// File: rtl/add_share_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// add_share_arbiter : round-robin arbiter sharing one WIDTH-bit adder among
//                     NREQ requesters, registered and id-tagged response.
// Revision: 1.0
// ---------------------------------------------------------------------------
module add_share_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = $clog2(NREQ),
  parameter int CNTW  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_carry,
  output logic [IDW-1:0]        rsp_id,
  output logic                  busy,
  output logic [CNTW-1:0]       op_count
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNTW-1:0]   op_count_q, op_count_d;

  logic              can_accept;
  logic              found;
  logic              accept;
  logic [IDW-1:0]    win;
  logic [IDW-1:0]    idx;
  int                idx_i;
  logic [WIDTH-1:0]  a_win, b_win;
  logic [WIDTH:0]    sum_full;
  logic [NREQ-1:0]   ready_c;

  assign can_accept = (state_q == EMPTY) | rsp_ready;

  // First valid requester at or after rr_ptr, wrapping at NREQ-1.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    idx_i = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx_i = int'(rr_ptr_q) + k;
      if (idx_i >= NREQ) begin
        idx_i = idx_i - NREQ;
      end
      idx = IDW'(idx_i);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    a_win   = '0;
    b_win   = '0;
    ready_c = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) begin
        a_win = req_a[i*WIDTH +: WIDTH];
        b_win = req_b[i*WIDTH +: WIDTH];
      end
      // Held low during reset so no requester sees a spurious accept.
      ready_c[i] = rst_n & found & can_accept & (win == IDW'(i));
    end
  end

  assign accept   = found & can_accept;
  assign sum_full = {1'b0, a_win} + {1'b0, b_win};

  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    id_d       = id_q;
    rr_ptr_d   = rr_ptr_q;
    op_count_d = op_count_q;

    if (accept) begin
      state_d  = FULL;
      sum_d    = sum_full[WIDTH-1:0];
      carry_d  = sum_full[WIDTH];
      id_d     = win;
      rr_ptr_d = (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
    end else if (rsp_ready) begin
      state_d = EMPTY;
    end

    if ((state_q == FULL) && rsp_ready && (op_count_q != {CNTW{1'b1}})) begin
      op_count_d = op_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      id_q       <= '0;
      rr_ptr_q   <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      id_q       <= id_d;
      rr_ptr_q   <= rr_ptr_d;
      op_count_q <= op_count_d;
    end
  end

  assign req_ready = ready_c;
  assign rsp_valid = (state_q == FULL);
  assign rsp_sum   = sum_q;
  assign rsp_carry = carry_q;
  assign rsp_id    = id_q;
  assign busy      = (state_q == FULL) & ~rsp_ready;
  assign op_count  = op_count_q;

endmodule
`default_nettype wire

// File: tb/tb_add_share_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_add_share_arbiter : directed self-checking bench for add_share_arbiter.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_add_share_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int CNTW  = 4;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_carry;
  logic [IDW-1:0]        rsp_id;
  logic                  busy;
  logic [CNTW-1:0]       op_count;

  int tests;
  int fails;

  add_share_arbiter #(
    .WIDTH(WIDTH),
    .NREQ (NREQ),
    .IDW  (IDW),
    .CNTW (CNTW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_sum  (rsp_sum),
    .rsp_carry(rsp_carry),
    .rsp_id   (rsp_id),
    .busy     (busy),
    .op_count (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    #1;
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %0b expected 0", rsp_valid); end
    tests++; if (rsp_sum !== 8'd0 || rsp_carry !== 1'b0 || rsp_id !== 2'd0) begin fails++;
      $display("FAIL reset_rsp_fields: got sum=%0d carry=%0b id=%0d expected 0/0/0", rsp_sum, rsp_carry, rsp_id); end
    tests++; if (op_count !== 4'd0) begin fails++; $display("FAIL reset_op_count: got %0d expected 0", op_count); end
    tick();
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    req_valid = '0;
    rst_n     = 1'b1;
    tick();
  endtask

  task automatic test_single();
    set_op(2, 8'd10, 8'd20);
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    @(negedge clk);
    tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
    tick();
    req_valid = '0;
    tests++; if (rsp_valid !== 1'b1 || rsp_sum !== 8'd30 || rsp_carry !== 1'b0 || rsp_id !== 2'd2) begin fails++;
      $display("FAIL single_rsp: got v=%0b sum=%0d c=%0b id=%0d expected 1/30/0/2", rsp_valid, rsp_sum, rsp_carry, rsp_id); end
    tick();
    tests++; if (rsp_valid !== 1'b0 || op_count !== 4'd1) begin fails++;
      $display("FAIL single_drain: got v=%0b count=%0d expected 0/1", rsp_valid, op_count); end
  endtask

  task automatic test_overflow();
    set_op(0, 8'd200, 8'd100);
    req_valid = 4'b0001;
    @(negedge clk);
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL overflow_ready: got %b expected 0001", req_ready); end
    tick();
    req_valid = '0;
    tests++; if (rsp_sum !== 8'd44 || rsp_carry !== 1'b1 || rsp_id !== 2'd0) begin fails++;
      $display("FAIL overflow_rsp: got sum=%0d c=%0b id=%0d expected 44/1/0", rsp_sum, rsp_carry, rsp_id); end
    tick();
    tests++; if (op_count !== 4'd2) begin fails++; $display("FAIL overflow_count: got %0d expected 2", op_count); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_ready;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 8'(i + 1), 8'(10 * i));
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp_ready = 4'b0001 << (k % 4);
      @(negedge clk);
      tests++; if (req_ready !== exp_ready) begin fails++;
        $display("FAIL rr_ready[%0d]: got %b expected %b", k, req_ready, exp_ready); end
      tick();
      tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(k % 4) || rsp_sum !== 8'((k % 4) + 1 + 10 * (k % 4))) begin fails++;
        $display("FAIL rr_rsp[%0d]: got v=%0b id=%0d sum=%0d expected 1/%0d/%0d", k, rsp_valid, rsp_id, rsp_sum,
                 k % 4, (k % 4) + 1 + 10 * (k % 4)); end
    end
    req_valid = '0;
    tick();
    tests++; if (rsp_valid !== 1'b0 || op_count !== 4'd6) begin fails++;
      $display("FAIL rr_drain: got v=%0b count=%0d expected 0/6", rsp_valid, op_count); end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_op(0, 8'd1, 8'd2);
    set_op(1, 8'd5, 8'd6);
    req_valid = 4'b0011;
    rsp_ready = 1'b1;
    @(negedge clk);
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL bp_first_ready: got %b expected 0001", req_ready); end
    tick();
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests++; if (rsp_valid !== 1'b1 || rsp_sum !== 8'd3 || rsp_id !== 2'd0 || busy !== 1'b1 || req_ready !== 4'b0000) begin fails++;
        $display("FAIL bp_hold[%0d]: got v=%0b sum=%0d id=%0d busy=%0b ready=%b expected 1/3/0/1/0000",
                 k, rsp_valid, rsp_sum, rsp_id, busy, req_ready); end
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    tests++; if (req_ready !== 4'b0010 || busy !== 1'b0) begin fails++;
      $display("FAIL bp_release: got ready=%b busy=%0b expected 0010/0", req_ready, busy); end
    tick();
    req_valid = '0;
    tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 8'd11 || op_count !== 4'd1) begin fails++;
      $display("FAIL bp_next: got v=%0b id=%0d sum=%0d count=%0d expected 1/1/11/1", rsp_valid, rsp_id, rsp_sum, op_count); end
    tick();
    tests++; if (op_count !== 4'd2) begin fails++; $display("FAIL bp_count: got %0d expected 2", op_count); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 8'(3 + i), 8'(8 + i));
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    tick();
    req_valid = 4'b1111;
    tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 8'd15) begin fails++;
      $display("FAIL mid_setup: got v=%0b id=%0d sum=%0d expected 1/2/15", rsp_valid, rsp_id, rsp_sum); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (rsp_valid !== 1'b0 || rsp_sum !== 8'd0 || rsp_id !== 2'd0 || req_ready !== 4'b0000 || busy !== 1'b0) begin fails++;
      $display("FAIL mid_async: got v=%0b sum=%0d id=%0d ready=%b busy=%0b expected 0/0/0/0000/0",
               rsp_valid, rsp_sum, rsp_id, req_ready, busy); end
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL mid_first_grant: got %b expected 0001", req_ready); end
    tick();
    req_valid = '0;
    tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 8'd11) begin fails++;
      $display("FAIL mid_first_rsp: got v=%0b id=%0d sum=%0d expected 1/0/11", rsp_valid, rsp_id, rsp_sum); end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    set_op(0, 8'd1, 8'd1);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 9) begin
        tests++; if (op_count !== 4'd9) begin fails++; $display("FAIL sat_mid: got %0d expected 9", op_count); end
      end
    end
    req_valid = '0;
    tick();
    tick();
    tests++; if (op_count !== 4'd15) begin fails++; $display("FAIL sat_final: got %0d expected 15", op_count); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single();
    test_overflow();
    test_round_robin();
    test_backpressure();
    test_mid_reset();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/add_share_arbiter.md
Name: add_share_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit adder among NREQ requesters.
- Each requester presents operands with a valid/ready handshake.
- One winner per cycle is added; the registered result is returned on a single response channel, tagged with the requester id.
- Sits between multiple datapath clients and the shared parameterized adder, replacing per-client adder instances.

Parameters:
- WIDTH, 8, operand and sum width in bits (>=1).
- NREQ, 4, number of requesters (2..16).
- IDW, $clog2(NREQ), width of the requester id (derived; do not override).
- CNTW, 16, width of the saturating completed-operation counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester operand valid.
- req_a  input  NREQ*WIDTH  packed operand A; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  packed operand B, same packing as req_a.
- req_ready  output  NREQ  per-requester accept; at most one bit high per cycle.
- rsp_valid  output  1  result register holds a valid result.
- rsp_ready  input  1  consumer accepts the result.
- rsp_sum  output  WIDTH  (a+b) mod 2^WIDTH.
- rsp_carry  output  1  carry out of the WIDTH-bit add.
- rsp_id  output  IDW  index of the requester that produced rsp_sum.
- busy  output  1  high when rsp_valid=1 and rsp_ready=0 (stalled).
- op_count  output  CNTW  completed responses (rsp_valid & rsp_ready); saturates at all-ones.

Behaviour:
- Reset (rst_n=0, async): rsp_valid=0, rsp_sum=0, rsp_carry=0, rsp_id=0, op_count=0, rr_ptr=0.
  - req_ready stays 0 while rst_n=0.
  - A mid-operation reset discards any held result without handshake.
- State, two states:
  - EMPTY (rsp_valid=0).
  - FULL (rsp_valid=1).
- can_accept = (state==EMPTY) | rsp_ready. Drain and refill in the same cycle is allowed, so full throughput is 1 op/cycle.
- Grant (combinational):
  - Search req_valid starting at index rr_ptr, ascending, wrapping from NREQ-1 to 0; the first set bit wins.
  - req_ready[win] = can_accept. All other req_ready bits = 0.
  - req_ready must not depend on rsp_valid of the same cycle beyond can_accept.
- Accept (req_valid[win] & req_ready[win]), at the next edge:
  - rsp_sum = a+b (low WIDTH bits); rsp_carry = bit WIDTH of the (WIDTH+1)-bit sum; rsp_id = win.
  - rsp_valid = 1 (FULL).
  - rr_ptr = (win+1) mod NREQ.
  - Latency: result visible 1 cycle after the accept edge.
- No accept and rsp_ready=1 while FULL: rsp_valid=0 (EMPTY).
- FULL and rsp_ready=0: rsp_sum, rsp_carry and rsp_id hold stable; no requester is granted.
- rr_ptr changes only on an accept. Idle cycles do not advance it.
- No requests valid: req_ready=0; state follows the drain rule above.
- Requesters must hold req_a/req_b/req_valid stable until accepted. The arbiter samples operands only on the accept edge.
- op_count increments on every rsp_valid & rsp_ready cycle and stops at 2^CNTW-1.
- Fairness: with all requesters continuously valid and rsp_ready=1, grants cycle 0,1,...,NREQ-1,0, and every requester is served within NREQ accepts.

Test Plan:
- Reset then single request (WIDTH=8, NREQ=4): req_valid=4'b0100, a2=10, b2=20, rsp_ready=1.
  - req_ready=4'b0100 in the same cycle.
  - Next cycle: rsp_valid=1, rsp_sum=30, rsp_carry=0, rsp_id=2.
  - op_count=1 after the drain.
- Overflow: a0=200, b0=100 -> rsp_sum=44, rsp_carry=1, rsp_id=0.
- Round-robin: all four requesters valid continuously, rsp_ready=1.
  - rsp_id sequence 0,1,2,3,0,1 on consecutive cycles; one accept per cycle.
- Backpressure: hold rsp_ready=0 for 5 cycles after the first result.
  - rsp_valid, rsp_sum and rsp_id stay stable; busy=1; req_ready=0.
  - Raising rsp_ready drains the held result and accepts the next requester in the same cycle.
- Mid-operation reset: assert rst_n=0 while FULL.
  - Outputs go to reset values immediately, without waiting for clk.
  - After release, the first grant goes to requester 0.
- Counter saturation (CNTW=4): 20 completed operations -> op_count stops at 15.
